// File: rtl/penc_pkg.sv
// penc_pkg: shared types and helpers for the priority-encoder arbiter.
// Holds the FSM state type, the largest supported request count and the
// wrap-around decrement used for the round-robin pointer (PENC_RR_EN).
package penc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_N = 64;

  // Step one index downward, wrapping 0 to n-1.
  function automatic int unsigned wrap_dec(input int unsigned k, input int unsigned n);
    return (k == 0) ? (n - 1) : (k - 1);
  endfunction

endpackage

// File: rtl/penc_pick.sv
// penc_pick: combinational downward-wrapping priority search.
// Starting at i_start, the first set request found walking down
// (i_start, i_start-1, ..., 0, N-1, ...) wins.
module penc_pick
  import penc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx,
  output logic [N-1:0] o_onehot
);

  localparam int unsigned NU = N;

  logic [W-1:0] w_st;
  logic         w_lo_hit;
  logic [W-1:0] w_lo_idx;
  logic         w_any_hit;
  logic [W-1:0] w_any_idx;

  // An out-of-range start pointer behaves as the top index.
  assign w_st = (32'(i_start) < NU) ? i_start : W'(NU - 1);

  // Two passes in one sweep: highest request at or below the start, and
  // highest request overall. The wrapped search picks the first if it
  // exists, otherwise the second (which must lie above the start).
  always_comb begin
    w_lo_hit  = 1'b0;
    w_lo_idx  = '0;
    w_any_hit = 1'b0;
    w_any_idx = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (i_req[k]) begin
        w_any_hit = 1'b1;
        w_any_idx = W'(k);
        if (k <= 32'(w_st)) begin
          w_lo_hit = 1'b1;
          w_lo_idx = W'(k);
        end
      end
    end
  end

  assign o_found = w_any_hit;
  assign o_idx   = w_lo_hit ? w_lo_idx : w_any_idx;

  // Decode the winning index to one-hot; all zero when nothing is found.
  always_comb begin
    o_onehot = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      o_onehot[k] = w_any_hit && (32'(o_idx) == k);
    end
  end

endmodule

// File: rtl/penc_arbiter.sv
// penc_arbiter: registered N-input priority encoder with a sticky
// valid/ready grant. Fixed priority (highest index wins) by default;
// defining PENC_RR_EN enables round-robin search from rr_ptr.
module penc_arbiter
  import penc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         busy
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_load;
  logic         w_found;
  logic [W-1:0] w_idx;
  logic [N-1:0] w_onehot;
  logic [W-1:0] w_start;

`ifdef PENC_RR_EN
  logic [W-1:0] r_rr_ptr;
  logic [W-1:0] w_rr_next;

  assign w_rr_next = W'(wrap_dec(32'(gnt_idx), N));
  // On a transfer the next winner is chosen from the pointer the transfer
  // is about to write, so back-to-back grants rotate without a bubble.
  assign w_start = (r_state == GRANT) ? w_rr_next : r_rr_ptr;

  // Round-robin pointer: moves just below each transferred index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= W'(N - 1);
    end else if ((r_state == GRANT) && gnt_ready) begin
      r_rr_ptr <= w_rr_next;
    end
  end
`else
  assign w_start = W'(N - 1);
`endif

  penc_pick #(.N(N)) u_pick (
    .i_req    (req),
    .i_start  (w_start),
    .o_found  (w_found),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // Next-state logic: issue from IDLE, reload or release on transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && w_found) begin
          w_state_nxt = GRANT;
          w_load      = 1'b1;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          if (en && w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        gnt_valid  <= 1'b1;
        gnt_idx    <= w_idx;
        gnt_onehot <= w_onehot;
      end else if (w_state_nxt == IDLE) begin
        gnt_valid  <= 1'b0;
        gnt_idx    <= '0;
        gnt_onehot <= '0;
      end
    end
  end

  assign busy = (r_state == GRANT);

endmodule

// File: tb/tb_penc_arbiter.sv
// tb_penc_arbiter: self-checking bench for penc_arbiter (N=8 and N=5).
// Round-robin expectations are enabled when PENC_RR_EN is defined.
module tb_penc_arbiter;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, gnt_ready;
  logic [7:0] req;
  logic       gnt_valid, busy;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;

  logic       en5, rdy5;
  logic [4:0] req5;
  logic       valid5, busy5;
  logic [2:0] idx5;
  logic [4:0] onehot5;

  int tests = 0;
  int fails = 0;

  // Reference model state for the N=8 instance.
  bit m_valid;
  int m_idx;
  int m_ptr;

  always #5 clk = ~clk;

  penc_arbiter #(.N(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .gnt_ready(gnt_ready),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot), .busy(busy)
  );

  penc_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .req(req5), .gnt_ready(rdy5),
    .gnt_valid(valid5), .gnt_idx(idx5), .gnt_onehot(onehot5), .busy(busy5)
  );

  // Winner = set request at the smallest downward distance from start.
  function automatic int winner(input logic [7:0] r, input int start);
    int best  = -1;
    int bestd = N;
    for (int k = 0; k < N; k++) begin
      if (r[k]) begin
        int d = (start - k + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = N - 1;
  endtask

  // Advance the model by one edge using the currently driven inputs,
  // then advance the clock and settle just past the edge.
  task automatic tick();
    if (!m_valid) begin
      if (en && req != 0) begin
        m_valid = 1'b1;
        m_idx   = winner(req, m_ptr);
      end
    end else if (gnt_ready) begin
`ifdef PENC_RR_EN
      m_ptr = (m_idx + N - 1) % N;
`endif
      if (en && req != 0) begin
        m_idx = winner(req, m_ptr);
      end else begin
        m_valid = 1'b0;
        m_idx   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; req = '0; gnt_ready = 1'b0;
    en5 = 1'b0; req5 = '0; rdy5 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #2;
    tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
    tests++; if (gnt_idx !== 3'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx); end
    tests++; if (gnt_onehot !== 8'h00) begin fails++; $display("FAIL reset_onehot got=%h exp=00", gnt_onehot); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick();
    req = 8'h20; en = 1'b1;
    tick();
    tests++; if (gnt_valid !== 1'b1) begin fails++; $display("FAIL single_valid got=%b exp=1", gnt_valid); end
    tests++; if (gnt_idx !== 3'd5) begin fails++; $display("FAIL single_idx got=%0d exp=5", gnt_idx); end
    tests++; if (gnt_onehot !== 8'h20) begin fails++; $display("FAIL single_onehot got=%h exp=20", gnt_onehot); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got=%b exp=1", busy); end
  endtask

  task automatic test_fixed_sticky();
    do_reset();
    en = 1'b1; req = 8'h81; gnt_ready = 1'b0;
    tick();
    tests++; if (gnt_idx !== 3'd7) begin fails++; $display("FAIL prio_idx got=%0d exp=7", gnt_idx); end
    req = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7 || gnt_onehot !== 8'h80) begin
        fails++;
        $display("FAIL sticky_hold cyc=%0d got v=%b i=%0d oh=%h exp v=1 i=7 oh=80", i, gnt_valid, gnt_idx, gnt_onehot);
      end
    end
    gnt_ready = 1'b1;
    tick();
    tests++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || gnt_onehot !== 8'h01) begin
      fails++; $display("FAIL sticky_next got v=%b i=%0d oh=%h exp v=1 i=0 oh=01", gnt_valid, gnt_idx, gnt_onehot); end
    req = 8'h00;
    tick();
    tests++; if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_onehot !== 8'h00 || busy !== 1'b0) begin
      fails++; $display("FAIL sticky_idle got v=%b i=%0d oh=%h exp v=0 i=0 oh=00", gnt_valid, gnt_idx, gnt_onehot); end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; req = 8'hFF; gnt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL en_low_valid cyc=%0d got=%b exp=0", i, gnt_valid); end
    end
    en = 1'b1; gnt_ready = 1'b0;
    tick();
    tests++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7) begin
      fails++; $display("FAIL en_grant got v=%b i=%0d exp v=1 i=7", gnt_valid, gnt_idx); end
    en = 1'b0; req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7) begin
        fails++; $display("FAIL en_drop_hold cyc=%0d got v=%b i=%0d exp v=1 i=7", i, gnt_valid, gnt_idx); end
    end
    gnt_ready = 1'b1; req = 8'hFF;
    tick();
    tests++; if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00) begin
      fails++; $display("FAIL en_release got v=%b oh=%h exp v=0 oh=00", gnt_valid, gnt_onehot); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_idx;
    do_reset();
    en = 1'b1; req = 8'h0C; gnt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
`ifdef PENC_RR_EN
      exp_idx = (i % 2 == 0) ? 3'd3 : 3'd2;
`else
      exp_idx = 3'd3;
`endif
      tests++; if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx) begin
        fails++; $display("FAIL b2b cyc=%0d got v=%b i=%0d exp v=1 i=%0d", i, gnt_valid, gnt_idx, exp_idx); end
    end
  endtask

`ifdef PENC_RR_EN
  task automatic test_round_robin();
    int seq1 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int seq2 [3] = '{3, 0, 3};
    do_reset();
    en = 1'b1; req = 8'hFF; gnt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      tests++; if (gnt_valid !== 1'b1 || int'(gnt_idx) != seq1[i]) begin
        fails++; $display("FAIL rr_ff step=%0d got=%0d exp=%0d", i, gnt_idx, seq1[i]); end
    end
    req = 8'h09;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (gnt_valid !== 1'b1 || int'(gnt_idx) != seq2[i]) begin
        fails++; $display("FAIL rr_09 step=%0d got=%0d exp=%0d", i, gnt_idx, seq2[i]); end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_oh;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      gnt_ready = ($urandom_range(0, 2) != 0);
      req       = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      tick();
      exp_oh = m_valid ? (8'h01 << m_idx) : 8'h00;
      tests++;
      if (gnt_valid !== m_valid || int'(gnt_idx) != m_idx || gnt_onehot !== exp_oh || busy !== m_valid) begin
        fails++;
        $display("FAIL random cyc=%0d got v=%b i=%0d oh=%h b=%b exp v=%b i=%0d oh=%h", i,
                 gnt_valid, gnt_idx, gnt_onehot, busy, m_valid, m_idx, exp_oh);
      end
    end
  endtask

  task automatic test_param_n5();
    do_reset();
    en = 1'b0; req = '0; gnt_ready = 1'b0;
    en5 = 1'b1; req5 = 5'b10010; rdy5 = 1'b0;
    tick();
    tests++; if (valid5 !== 1'b1 || idx5 !== 3'd4 || onehot5 !== 5'b10000) begin
      fails++; $display("FAIL n5_grant got v=%b i=%0d oh=%b exp v=1 i=4 oh=10000", valid5, idx5, onehot5); end
    req5 = 5'b00011; rdy5 = 1'b1;
    tick();
    tests++; if (valid5 !== 1'b1 || idx5 !== 3'd1 || onehot5 !== 5'b00010) begin
      fails++; $display("FAIL n5_next got v=%b i=%0d oh=%b exp v=1 i=1 oh=00010", valid5, idx5, onehot5); end
    rdy5 = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    tests++; if (valid5 !== 1'b0 || onehot5 !== 5'b00000 || busy5 !== 1'b0) begin
      fails++; $display("FAIL n5_async_rst got v=%b oh=%b b=%b exp v=0 oh=00000 b=0", valid5, onehot5, busy5); end
    rst = 1'b0;
    en5 = 1'b0; req5 = '0;
    tick();
    tests++; if (valid5 !== 1'b0) begin fails++; $display("FAIL n5_after_rst got=%b exp=0", valid5); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed_sticky();
    test_enable();
    test_back_to_back();
`ifdef PENC_RR_EN
    test_round_robin();
`endif
    test_random();
    test_param_n5();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
